// File: rtl/font_stream_ctrl.sv
// font_stream_ctrl: renders a latched multi-digit octal value as a stream of
// 8-bit glyph columns (MSB digit first, columns left to right) read from an
// external combinational font ROM, with optional leading-zero blanking.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                frame request, sampled only in IDLE
//   value                octal digits, digit k at bits [3k+2:3k]
//   blank_lz             leading-zero blanking enable, sampled with start
//   busy, done           frame in progress / one-cycle completion pulse
//   rom_digit/rom_column font ROM address (combinational from registers)
//   rom_data             font ROM column byte
//   col_data/col_valid/col_ready/col_last  column beat stream
module font_stream_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned GLYPH_COLS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              rom_digit,
  output logic [2:0]              rom_column,
  input  logic [7:0]              rom_data,
  output logic [7:0]              col_data,
  output logic                    col_valid,
  input  logic                    col_ready,
  output logic                    col_last
);

  localparam int unsigned VAL_W     = 3 * NUM_DIGITS;
  localparam logic [2:0]  FIRST_DIG = 3'(NUM_DIGITS - 1);
  localparam logic [2:0]  LAST_COL  = 3'(GLYPH_COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [VAL_W-1:0]   val_q;
  logic [2:0]         dig_idx;
  logic [2:0]         col_idx;
  logic               lz_active;
  logic [2:0]         cur_digit;
  logic               blank;
  logic               load;
  logic               hs;
  logic               final_beat;

  // Select the digit currently being rendered.
  always_comb begin
    cur_digit = 3'd0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (dig_idx == 3'(k)) cur_digit = val_q[3*k +: 3];
    end
  end

  assign rom_digit  = cur_digit;
  assign rom_column = col_idx;

  // Digit 0 is never blanked so an all-zero value still shows one "0".
  assign blank      = lz_active && (cur_digit == 3'd0) && (dig_idx != 3'd0);
  assign load       = (state == EMIT) && (!col_valid || col_ready);
  assign hs         = col_valid && col_ready;
  assign final_beat = (dig_idx == 3'd0) && (col_idx == LAST_COL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EMIT;
      EMIT:    if (load && final_beat) state_nxt = FLUSH;
      FLUSH:   if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame counters, beat register and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q     <= '0;
      dig_idx   <= 3'd0;
      col_idx   <= 3'd0;
      lz_active <= 1'b0;
      col_data  <= 8'h00;
      col_valid <= 1'b0;
      col_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == FLUSH) && hs;

      if (state == IDLE && start) begin
        val_q     <= value;
        dig_idx   <= FIRST_DIG;
        col_idx   <= 3'd0;
        lz_active <= blank_lz;
      end

      if (load) begin
        col_data  <= blank ? 8'h00 : rom_data;
        col_valid <= 1'b1;
        col_last  <= final_beat;
        if (col_idx == LAST_COL) begin
          col_idx <= 3'd0;
          // Hold the digit index on the final beat instead of wrapping.
          if (!final_beat) dig_idx <= dig_idx - 3'd1;
          if (!blank) lz_active <= 1'b0;
        end else begin
          col_idx <= col_idx + 3'd1;
        end
      end else if (hs) begin
        col_valid <= 1'b0;
        col_last  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/font_stream_ctrl.md
# font_stream_ctrl

Sequencer that renders a multi-digit octal value as a stream of 8-bit glyph columns for the waveforms peripheral display path. On `start` it latches the value, walks digits MSB-first and columns left-to-right, drives the address of the combinational font ROM (`font_rom`), and emits one column byte per beat over a valid/ready interface. It supports optional leading-zero blanking. It is the only master of the ROM address.

## Interface
- `NUM_DIGITS`, default 4: digits per frame, 1..8.
- `GLYPH_COLS`, default 5: columns emitted per digit, 1..8, starting at ROM column 0.
- `clk` in, 1: system clock; all state updates on the rising edge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `start` in, 1: frame request; sampled only in IDLE.
- `value` in, 3*NUM_DIGITS: octal digits; bits [3k+2:3k] are digit k, digit 0 is least significant. Sampled with `start`.
- `blank_lz` in, 1: enable leading-zero blanking; sampled with `start`.
- `busy` out, 1: high from the cycle after accepted `start` until the frame completes.
- `done` out, 1: one-cycle pulse at frame completion.
- `rom_digit` out, 3: ROM digit address, combinational from registers.
- `rom_column` out, 3: ROM column address, combinational from registers.
- `rom_data` in, 8: ROM output, combinational from the address.
- `col_data` out, 8: registered column byte.
- `col_valid` out, 1: `col_data` is valid.
- `col_ready` in, 1: consumer accepts the beat when high together with `col_valid`.
- `col_last` out, 1: marks the final beat of the frame; valid only with `col_valid`.

## Operation
- FSM states:
  - IDLE: on `start`, latch `value`/`blank_lz`, set `dig_idx`=NUM_DIGITS-1, `col_idx`=0, `lz_active`=`blank_lz`, then go to EMIT.
  - EMIT: issue beats until all NUM_DIGITS*GLYPH_COLS are loaded, then go to FLUSH.
  - FLUSH: wait for the final handshake, pulse `done`, return to IDLE.
- Address outputs: `rom_digit` = latched digit[`dig_idx`]; `rom_column` = `col_idx`.
- Blanking: current digit is blank when `lz_active` && digit==0 && `dig_idx`!=0. Digit 0 is never blanked, so an all-zero value shows a single "0".
- A blank digit emits 8'h00 for all its columns instead of `rom_data`.
- `lz_active` clears when advancing past a non-blank digit and stays clear for the rest of the frame.
- Load condition in EMIT: (!`col_valid` || `col_ready`).
  - On load: `col_data` <= blank ? 0 : `rom_data`; `col_valid` <= 1; `col_last` <= (`dig_idx`==0 && `col_idx`==GLYPH_COLS-1).
  - Counters advance: `col_idx`++. When `col_idx` == GLYPH_COLS-1, set `col_idx`=0 and `dig_idx`--. The load of the final beat goes to FLUSH.
- A handshake with no new load clears `col_valid`. `col_data` holds its value while `col_valid` is high and `col_ready` is low.
- `start` while not IDLE is ignored; there is no queueing.
- `busy` is high in EMIT and FLUSH.
- Reset values: `busy`=0, `done`=0, `col_valid`=0, `col_last`=0, `col_data`=8'h00, `rom_digit`=0, `rom_column`=0; state is IDLE.
- Reset mid-frame aborts immediately and drops the in-flight beat. No `done` is issued.

## Timing
- `start` is sampled at edge N; state is EMIT after N, and ROM is addressed for the first column in cycle N+1.
- The first `col_valid` appears after edge N+1.
- With `col_ready` held high, beats are back-to-back: NUM_DIGITS*GLYPH_COLS consecutive cycles.
- `done` is high for exactly the one cycle after the final handshake edge. `busy` falls in that same cycle.
- Earliest next `start` is accepted the cycle `done` is high; state is IDLE then.
- Backpressure stalls counters and address outputs with no lost or duplicated beats.
- ROM path is single-cycle combinational: address register -> `font_rom` -> `col_data` register.

## Test plan
- Defaults, `value`={1,2,3,4} (MSB first), `blank_lz`=0, ready=1 -> 20 beats on consecutive cycles:
  - 00 44 7E 40 00
  - 00 32 2A 24 00
  - 00 22 2A 14 00
  - 00 0E 08 3C 00
  - `col_last` only on beat 20; `done` one cycle later.
- `value`={0,0,5,0}, `blank_lz`=1 -> 10 beats of 00, then 00 26 2A 12 00, then 00 3C 42 3C 00 (inner zero not blanked).
- All-zero value, `blank_lz`=1 -> 15 beats 00, then 00 3C 42 3C 00; `done` pulses once.
- Random `col_ready` (about 50% duty) on the {1,2,3,4} frame:
  - Accepted sequence matches the first scenario exactly.
  - `col_data` is stable while stalled.
  - `start` pulses mid-frame have no effect.
- Deassert `rst_n` asynchronously at beat 7 -> outputs go to reset values immediately and no `done` is seen. After release, a new `start` produces a full correct frame.
